demux5_tdm: RTL
===============

// Module: demux5_tdm
// PURPOSE
//  1:5 time-division demultiplexer, the receive end of the 5:1 slot-mux path.
//  Accepts a serial word stream (one word per slot, slots 0..4 in order), assembles
//  a 5-lane frame and presents it on registered lane outputs with a valid/ready handshake.
//  Sits between the serial link and the parallel datapath consuming lanes 0..4.
// PARAMETERS
//  W            1    width of each slot word / output lane
// PORTS
//  clk          in   1     system clock, all state on rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  sync         in   1     slot restart: next accepted word is slot 0
//  din          in   W     serial slot word
//  in_valid     in   1     din valid this cycle
//  in_ready     out  1     block can accept din this cycle
//  dout         out  5*W   frame; lane k = dout[k*W +: W]
//  out_valid    out  1     dout holds a complete frame
//  out_ready    in   1     consumer takes frame when out_valid&out_ready
//  slot         out  3     current slot index (next word's destination)
//  parity_err   out  1     frame parity mismatch (DEMUX5_PARITY_EN only, else 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): slot=0, assembly reg=0, dout=0, out_valid=0, parity_err=0.
//  - Accept = in_valid & in_ready. On accept: asm[slot] <= din; slot <= slot+1.
//  - Slot range 0..LAST, LAST=4 (5 with parity). Accept at slot==LAST: slot wraps to 0,
//    asm lanes 0..4 (with last word) copied to dout next edge, out_valid<=1. Latency:
//    last word accepted at edge N -> out_valid high after edge N.
//  - Slots 5..7 unreachable without parity; 5 is parity slot with it; 6,7 never occur.
//  - out_valid clears on out_valid&out_ready unless a new frame completes same cycle
//    (then dout reloads, out_valid stays 1). dout stable while out_valid&!out_ready.
//  - in_ready = !(slot==LAST & out_valid & !out_ready): slots 0..LAST-1 always accepted
//    (double buffer); only the frame-completing word stalls on a held frame.
//  - sync=1: slot forced to 0, partial asm discarded (not cleared); if accept same cycle,
//    din written to lane 0 and slot<=1. sync never affects dout/out_valid.
//  - in_valid with in_ready=0: no state change; word must be held by sender.
//  - reset_n low mid-frame: partial frame and pending out frame lost, outputs to reset values.
// CONFIGURATION
//  DEMUX5_PARITY_EN defined: LAST=5; slot 5 word is even parity = XOR of lanes 0..4
//   (bitwise, W bits); not stored in dout. parity_err <= (XOR lanes ^ slot5 word)!=0,
//   loaded with dout, valid only while out_valid; frame still delivered on error.
//  Undefined: LAST=4, parity_err tied 0, no parity logic.
// STRUCTURE
//  demux5_pkg: NUM_LANES=5, slot_t (logic[2:0]), SLOT_LAST_NOPAR=3'd4, SLOT_PARITY=3'd5.
//  Sub-module demux5_slot_ctr: slot counter with sync restart, enable, wrap at LAST,
//   outputs slot and last flag. Top holds asm reg, output reg, handshake, parity check.
// TESTING
//  1 Reset: reset_n=0 mid-frame -> slot=0, out_valid=0, dout=0 immediately (async).
//  2 W=4, in_valid=1, out_ready=1, din 1,2,3,4,5 -> out_valid 1 cycle after 5th word,
//    dout={5,4,3,2,1}, slot back to 0.
//  3 Backpressure: out_ready=0, send two frames -> 2nd frame's 4 words accepted,
//    in_ready=0 at slot 4, dout holds frame 1; out_ready=1 -> frame 2 loads, in_ready=1.
//  4 sync after 3 words then 5 words A..E -> dout={E,D,C,B,A}; earlier 3 words never appear.
//  5 sync with accept of X -> X lands in lane 0, slot=1.
//  6 PARITY_EN, W=1: lanes 1,0,1,1,0 + parity 1 -> parity_err=0; parity 0 -> parity_err=1.

Source files
------------

// File: rtl/demux5_pkg.sv
// Shared types and constants for the 1:5 slot demultiplexer.
// DEMUX5_PARITY_EN adds a sixth (parity) slot per frame.
package demux5_pkg;

  localparam int NUM_LANES = 5;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_LAST_NOPAR = 3'd4;
  localparam slot_t SLOT_PARITY     = 3'd5;

`ifdef DEMUX5_PARITY_EN
  localparam slot_t SLOT_LAST = SLOT_PARITY;
`else
  localparam slot_t SLOT_LAST = SLOT_LAST_NOPAR;
`endif

endpackage

// File: rtl/demux5_slot_ctr.sv
// Slot counter: sync restart, enable, wrap at SLOT_LAST.
// Honours DEMUX5_PARITY_EN through demux5_pkg::SLOT_LAST.
import demux5_pkg::*;

module demux5_slot_ctr (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  sync_i,
  input  logic  en_i,
  output slot_t slot_o,
  output logic  last_o
);

  slot_t slot_q;
  slot_t slot_d;

  assign slot_o = slot_q;
  assign last_o = (slot_q == SLOT_LAST);

  // A word accepted alongside sync lands in slot 0.
  always_comb begin
    slot_d = slot_q;
    if (sync_i) begin
      slot_d = en_i ? 3'd1 : 3'd0;
    end else if (en_i) begin
      slot_d = last_o ? 3'd0 : slot_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/demux5_tdm.sv
// 1:5 TDM demultiplexer: assembles serial slots into a 5-lane frame.
// DEMUX5_PARITY_EN enables the even-parity slot and parity_err.
import demux5_pkg::*;

module demux5_tdm #(
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync,
  input  logic [W-1:0]         din,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_LANES*W-1:0] dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           slot,
  output logic                 parity_err
);

  logic  accept;
  logic  last;
  logic  done;
  slot_t wr_slot;

  logic [NUM_LANES-1:0][W-1:0] asm_q;
  logic [NUM_LANES-1:0][W-1:0] frame_d;
  logic [NUM_LANES-1:0][W-1:0] dout_q;
  logic                        out_valid_q;

  assign in_ready = !(last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign wr_slot  = sync ? slot_t'(0) : slot;
  assign done     = accept && last && !sync;

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

  demux5_slot_ctr u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_i  (sync),
    .en_i    (accept),
    .slot_o  (slot),
    .last_o  (last)
  );

  // Partial frames are overwritten, never cleared, on sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (accept && wr_slot == slot_t'(k)) begin
          asm_q[k] <= din;
        end
      end
    end
  end

  always_comb begin
    frame_d = asm_q;
`ifndef DEMUX5_PARITY_EN
    frame_d[NUM_LANES-1] = din;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (done) begin
      dout_q      <= frame_d;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef DEMUX5_PARITY_EN
  logic [W-1:0] par_d;
  logic         perr_q;

  always_comb begin
    par_d = din;
    for (int k = 0; k < NUM_LANES; k++) begin
      par_d = par_d ^ frame_d[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else if (done) begin
      perr_q <= |par_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
